int_source_latch: RTL
=====================

Name: int_source_latch

Overview:
- Upstream feeder for the 4-input interrupt priority stage.
- Takes four raw asynchronous interrupt sources (board buttons/switches or peripheral strobes) and synchronizes each one.
- Debounces each source and detects its rising edge, then holds it as a sticky pending bit until the CPU acknowledges it.
- pending[3:0] drives the priority stage's request inputs directly; index 0 is highest priority, matching that stage.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive cycles a synchronized level must differ from the debounced level before it is accepted (>=1; board builds use 1000000).
- CNT_W, 20, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- raw_in  input  4  raw asynchronous interrupt sources, active-high.
- mask  input  4  per-source enable; 1 = edge may set pending.
- ack  input  1  one-cycle pulse from the CPU: the interrupt for source ack_id has been taken.
- ack_id  input  2  source index being acknowledged.
- clr_all  input  1  synchronous clear of all pending and lost bits.
- pending  output  4  registered sticky pending bits (feeds the priority stage's in[3:0]).
- any_pending  output  1  OR of pending, registered together with pending.
- lost  output  4  sticky flag: an edge arrived while that source was already pending.
- level  output  4  debounced levels (debug/LEDs).

Behaviour:
- Reset (async, rst_n=0): sync flops, level, counters, pending, lost and any_pending all become 0 immediately. No edge is generated on release, even if raw_in is already high. A source held high through reset release sets pending once the debounce completes.
- Synchronizer: two flops per bit, raw_in -> s1 -> s2.
- Debounce, per bit, evaluated on every clock edge:
  - If s2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Pulses on s2 shorter than DEBOUNCE_CYCLES cycles never change level.
- Rise event, per bit: the edge on which level goes 0->1 and mask[i]=1. The mask is sampled on that edge only.
  - A masked rise is discarded, not deferred.
  - Falling level changes produce nothing.
- Latency: counting the first edge that samples raw_in[i]=1 as edge 1, pending[i] is high after edge DEBOUNCE_CYCLES+2.
- Pending update, per bit, with priority in this order:
  1. clr_all: pending <= 0, lost <= 0.
  2. Rise event: pending <= 1. If pending was already 1 and no ack clears bit i on this edge, lost <= 1.
  3. ack && ack_id==i: pending <= 0, lost <= 0.
- Simultaneous rise and ack on the same bit: the rise wins, so pending stays 1 and lost stays 0. A new event is never dropped.
- Ack of a bit that is not pending has no effect and no error.
- Changing mask never clears an existing pending bit.
- any_pending equals the OR of the next-state pending bits, so it is aligned with pending.
- Multiple sources may be pending together. Arbitration belongs to the downstream priority stage.

Test Plan:
- Reset/idle (D=4): hold rst_n=0 with raw_in=4'b1111, release -> pending=0 after release; pending=4'b1111 after edge 6; any_pending=1.
- Latency and glitch: raw_in[2] high 3 cycles then low -> level and pending stay 0. raw_in[2] held high -> pending=4'b0100 after edge 6, level[2]=1.
- Mask: mask=4'b1110, raw_in[0] rises -> pending[0] stays 0. Set mask[0]=1 while raw_in[0] is still high -> still 0. Drop raw_in[0] low and raise it again -> pending[0]=1.
- Ack/lost: pending[1]=1, second debounced edge on raw_in[1] -> lost=4'b0010. ack with ack_id=1 -> pending[1]=0 and lost[1]=0 the next cycle.
- Collision: time an ack of id 3 onto the edge where level[3] rises -> pending[3]=1, lost[3]=0. Then clr_all on a rise edge -> pending=0, lost=0.
- Async reset mid-debounce: rst_n pulsed low between clock edges at cnt=2 -> all outputs 0 immediately and the count restarts from 0.

Source files
------------

// File: rtl/int_source_latch.sv
// rtl/int_source_latch.sv - synchronize, debounce and latch four interrupt sources as sticky pending bits
module int_source_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_in,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_id,
  input  logic       clr_all,
  output logic [3:0] pending,
  output logic       any_pending,
  output logic [3:0] lost,
  output logic [3:0] level
);

  // Terminal count: the synchronized level has differed for DEBOUNCE_CYCLES edges
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       rise;
  logic [3:0]       pending_nxt;
  logic [3:0]       lost_nxt;

  // Two-flop synchronizer per source; reset low so release never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Debounce: accept s2 only after it has differed from level for the full window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rise event: level is about to go 0->1 on this edge and the source is enabled now
  always_comb begin
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      rise[i] = !level[i] && s2[i] && (cnt[i] == CNT_LAST) && mask[i];
    end
  end

  // Next pending/lost: clear-all beats a new rise, a new rise beats an ack
  always_comb begin
    pending_nxt = pending;
    lost_nxt    = lost;
    for (int i = 0; i < 4; i++) begin
      if (clr_all) begin
        pending_nxt[i] = 1'b0;
        lost_nxt[i]    = 1'b0;
      end else if (rise[i]) begin
        pending_nxt[i] = 1'b1;
        if (pending[i] && !(ack && ack_id == 2'(i))) lost_nxt[i] = 1'b1;
      end else if (ack && ack_id == 2'(i)) begin
        pending_nxt[i] = 1'b0;
        lost_nxt[i]    = 1'b0;
      end
    end
  end

  // Register the sticky bits; any_pending comes from the same next state so it lines up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      lost        <= '0;
      any_pending <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      lost        <= lost_nxt;
      any_pending <= |pending_nxt;
    end
  end

endmodule
